// File: rtl/multicycle_sequencer.sv
// Multi-cycle phase controller for the KGP_RISC datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and
// handshakes with the instruction and data memories. It flags halt,
// illegal-opcode and memory-timeout conditions, and counts retired instructions.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             alu_en,
  output logic             dmem_rd_req,
  output logic             dmem_wr_req,
  output logic             reg_write_en,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExecute = 3'd3,
    StMem     = 3'd4,
    StWb      = 3'd5,
    StHalt    = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu, ClsLoad, ClsStore, ClsUbr, ClsCbr, ClsLink, ClsHlt, ClsIll
  } cls_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cls_e             cls;

  // Map the opcode to its instruction class.
  always_comb begin
    cls = ClsIll;
    case (opcode)
      6'b000000, 6'b001000: cls = ClsAlu;
      6'b100000:            cls = ClsLoad;
      6'b100001:            cls = ClsStore;
      6'b010000, 6'b010001: cls = ClsUbr;
      6'b010010:            cls = ClsCbr;
      6'b010011:            cls = ClsLink;
      6'b111111:            cls = ClsHlt;
      default:              cls = ClsIll;
    endcase
  end

  // Next-state, counters and phase strobes.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_branch    = 1'b0;
    alu_en       = 1'b0;
    dmem_rd_req  = 1'b0;
    dmem_wr_req  = 1'b0;
    reg_write_en = 1'b0;
    halted       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        // Ready takes priority over a timeout landing in the same cycle.
        if (imem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = StDecode;
        end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
          err_d   = 2'b01;
          state_d = StHalt;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDecode: begin
        if (cls == ClsHlt) begin
          state_d = StHalt;
        end else if (cls == ClsIll) begin
          err_d   = 2'b11;
          state_d = StHalt;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        alu_en = 1'b1;
        case (cls)
          ClsAlu:            state_d = StWb;
          ClsLoad, ClsStore: state_d = StMem;
          ClsUbr: begin
            pc_branch = 1'b1;
            state_d   = StFetch;
          end
          ClsCbr: begin
            pc_branch = branch_taken;
            state_d   = StFetch;
          end
          ClsLink: begin
            pc_branch = 1'b1;
            state_d   = StWb;
          end
          // Opcode changed under us after DECODE: treat as illegal.
          default: begin
            err_d   = 2'b11;
            state_d = StHalt;
          end
        endcase
      end
      StMem: begin
        dmem_rd_req = (cls == ClsLoad);
        dmem_wr_req = (cls == ClsStore);
        if (dmem_ready) begin
          state_d = (cls == ClsLoad) ? StWb : StFetch;
        end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
          err_d   = 2'b10;
          state_d = StHalt;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWb: begin
        reg_write_en = 1'b1;
        state_d      = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
        if (start) begin
          err_d   = 2'b00;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) wait_d = '0;

    // Retire only when an instruction completes back into FETCH; saturate.
    if (state_d == StFetch &&
        (state_q == StExecute || state_q == StMem || state_q == StWb) &&
        cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
      err_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = (state_q != StIdle) && (state_q != StHalt);
  assign err_code    = err_q;
  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: phase sequencing, handshakes,
// timeouts, illegal/halt opcodes and asynchronous reset.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_req, ir_load, pc_inc, pc_branch, alu_en;
  logic        dmem_rd_req, dmem_wr_req, reg_write_en, busy, halted;
  logic [1:0]  err_code;
  logic [15:0] instr_count;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  multicycle_sequencer #(.TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch),
    .alu_en(alu_en), .dmem_rd_req(dmem_rd_req), .dmem_wr_req(dmem_wr_req),
    .reg_write_en(reg_write_en), .busy(busy), .halted(halted), .err_code(err_code),
    .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++;
    if ({busy, halted, err_code} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {busy, halted, err_code});
    end
    checks++;
    if (instr_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", instr_count);
    end
    checks++;
    if ({imem_req, ir_load, pc_inc, pc_branch, alu_en, dmem_rd_req, dmem_wr_req,
         reg_write_en} !== 8'h00) begin
      errors++; $display("FAIL reset_strobes: got nonzero want 00");
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", state); end
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL start_fetch: got %0d want 1", state); end
  endtask

  // ALU instruction with readies tied high; start held while busy must be ignored.
  task automatic test_alu();
    logic [2:0] exp_st [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    int wb_cnt = 0;
    int wb_idx = -1;
    opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      #1;
      checks++;
      if (state !== exp_st[i]) begin
        errors++; $display("FAIL alu_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL alu_busy[%0d]: got %b want 1", i, busy); end
      if (reg_write_en) begin wb_cnt++; wb_idx = i; end
      if (i == 0 || i == 4) begin
        checks++;
        if ({ir_load, pc_inc} !== 2'b11) begin
          errors++; $display("FAIL alu_irload[%0d]: got %b want 11", i, {ir_load, pc_inc});
        end
      end
      if (i == 2) begin
        checks++;
        if (alu_en !== 1'b1) begin errors++; $display("FAIL alu_en: got %b want 1", alu_en); end
      end
      if (i < 4) tick();
    end
    start = 1'b0;
    checks++;
    if (wb_cnt !== 1 || wb_idx !== 3) begin
      errors++; $display("FAIL alu_wb: got cnt=%0d idx=%0d want cnt=1 idx=3", wb_cnt, wb_idx);
    end
    checks++;
    if (instr_count !== 16'd1) begin
      errors++; $display("FAIL alu_count: got %0d want 1", instr_count);
    end
  endtask

  // LOAD with dmem_ready arriving on the fourth MEM cycle.
  task automatic test_load_wait();
    int rd_cnt = 0;
    int wb_cnt = 0;
    int next_ir = -1;
    opcode = 6'b100000;
    for (int i = 0; i < 9; i++) begin
      dmem_ready = (i == 6);
      #1;
      if (dmem_rd_req) rd_cnt++;
      if (reg_write_en) wb_cnt++;
      if (i > 0 && ir_load && next_ir < 0) next_ir = i;
      if (i == 7) begin
        checks++;
        if (state !== 3'd5) begin errors++; $display("FAIL load_wb_state: got %0d want 5", state); end
      end
      if (i < 8) tick();
    end
    dmem_ready = 1'b1;
    checks++;
    if (rd_cnt !== 4) begin errors++; $display("FAIL load_rd_hold: got %0d want 4", rd_cnt); end
    checks++;
    if (wb_cnt !== 1) begin errors++; $display("FAIL load_wb: got %0d want 1", wb_cnt); end
    checks++;
    if (next_ir !== 8) begin errors++; $display("FAIL load_latency: got %0d want 8", next_ir); end
    checks++;
    if (instr_count !== 16'd2) begin
      errors++; $display("FAIL load_count: got %0d want 2", instr_count);
    end
  endtask

  // Conditional branch, not taken then taken: 3 cycles each, no writeback.
  task automatic test_cbr();
    opcode = 6'b010010;
    for (int n = 0; n < 2; n++) begin
      int wb_cnt = 0;
      branch_taken = (n == 1);
      for (int i = 0; i < 4; i++) begin
        #1;
        if (reg_write_en) wb_cnt++;
        if (i == 2) begin
          checks++;
          if (pc_branch !== branch_taken) begin
            errors++; $display("FAIL cbr_branch[%0d]: got %b want %b", n, pc_branch, branch_taken);
          end
        end
        if (i < 3) tick();
      end
      checks++;
      if (state !== 3'd1 || ir_load !== 1'b1) begin
        errors++; $display("FAIL cbr_latency[%0d]: got state=%0d ir=%b want 1/1", n, state, ir_load);
      end
      checks++;
      if (wb_cnt !== 0) begin errors++; $display("FAIL cbr_wb[%0d]: got %0d want 0", n, wb_cnt); end
    end
    checks++;
    if (instr_count !== 16'd4) begin
      errors++; $display("FAIL cbr_count: got %0d want 4", instr_count);
    end
  endtask

  // imem_ready held low: 16 FETCH cycles then HALT with fetch-timeout.
  task automatic test_fetch_timeout();
    int fetch_cycles = 0;
    imem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (state == 3'd1) fetch_cycles++;
      tick();
    end
    #1;
    checks++;
    if (fetch_cycles !== 16) begin
      errors++; $display("FAIL to_fetch_cycles: got %0d want 16", fetch_cycles);
    end
    checks++;
    if (state !== 3'd6 || halted !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL to_halt: got state=%0d halted=%b busy=%b want 6/1/0",
                         state, halted, busy);
    end
    checks++;
    if (err_code !== 2'b01) begin errors++; $display("FAIL to_err: got %b want 01", err_code); end
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL to_halt_req: got %b want 0", imem_req); end
    imem_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || err_code !== 2'b00 || instr_count !== 16'd4) begin
      errors++; $display("FAIL to_restart: got state=%0d err=%b cnt=%0d want 1/00/4",
                         state, err_code, instr_count);
    end
  endtask

  // Illegal opcode halts with err 11; HLT halts with err 00; neither retires.
  task automatic test_illegal_and_halt();
    logic [5:0] ops [2] = '{6'b000111, 6'b111111};
    logic [1:0] errs [2] = '{2'b11, 2'b00};
    for (int n = 0; n < 2; n++) begin
      opcode = ops[n];
      tick();
      #1;
      checks++;
      if (state !== 3'd2) begin errors++; $display("FAIL ill_decode[%0d]: got %0d want 2", n, state); end
      tick();
      checks++;
      if (state !== 3'd6 || err_code !== errs[n]) begin
        errors++; $display("FAIL ill_halt[%0d]: got state=%0d err=%b want 6/%b",
                           n, state, err_code, errs[n]);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    checks++;
    if (instr_count !== 16'd4) begin
      errors++; $display("FAIL ill_count: got %0d want 4", instr_count);
    end
  endtask

  // Async reset mid-MEM of a STORE drops the write request immediately.
  task automatic test_reset_mid_store();
    opcode = 6'b100001;
    dmem_ready = 1'b0;
    tick();
    tick();
    tick();
    #1;
    checks++;
    if (state !== 3'd4 || dmem_wr_req !== 1'b1 || dmem_rd_req !== 1'b0) begin
      errors++; $display("FAIL st_mem: got state=%0d wr=%b rd=%b want 4/1/0",
                         state, dmem_wr_req, dmem_rd_req);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (dmem_wr_req !== 1'b0 || state !== 3'd0 || instr_count !== 16'd0) begin
      errors++; $display("FAIL st_reset: got wr=%b state=%0d cnt=%0d want 0/0/0",
                         dmem_wr_req, state, instr_count);
    end
    checks++;
    if (busy !== 1'b0 || alu_en !== 1'b0) begin
      errors++; $display("FAIL st_reset_quiet: got busy=%b alu=%b want 0/0", busy, alu_en);
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_cbr();
    test_fetch_timeout();
    test_illegal_and_halt();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
